hb_dn2_dec2: RTL and testbench
==============================

HB_DN2_DEC2 -- requirements
Module: hb_dn2_dec2

Interface
REQ-001 The block SHALL have parameter XIN_WIDTH, default 16, input sample width in bits (signed).
REQ-002 The block SHALL have parameter COE_WIDTH, default 16, coefficient width in bits (signed).
REQ-003 The block SHALL have parameter NUM_UNIQUE_COE, default 5, number of unique non-center taps N.
REQ-004 The block SHALL have parameter COE_NUMS, default {952, -1609, 3090, -6260, 20622}, the unique taps c_0..c_{N-1}.
REQ-005 The block SHALL have parameter YOUT_WIDTH, default 16, output width in bits (signed).
REQ-006 The block SHALL have parameter SRA_BITS, default 15, the final arithmetic right shift.
REQ-007 The block SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-008 The block SHALL have port rst_n, input, 1 bit, reset; reset is asynchronous and active-low.
REQ-009 The block SHALL have port xin, input, XIN_WIDTH bits, input sample at rate fs.
REQ-010 The block SHALL have port xin_valid, input, 1 bit, marks xin as valid for the cycle.
REQ-011 The block SHALL have port yout, output, YOUT_WIDTH bits, decimated sample at rate fs/2.
REQ-012 The block SHALL have port yout_valid, output, 1 bit, single-cycle strobe qualifying yout and ovf.
REQ-013 The block SHALL have port ovf, output, 1 bit, saturation flag for the current yout.

Function
REQ-014 The block SHALL accept a sample on every cycle with xin_valid=1, index accepted samples x[n] from n=0, and ignore xin when xin_valid=0 (gaps allowed, no backpressure).
REQ-015 The filter SHALL be an odd-length half-band filter of 4N-1 taps: h[2k]=h[4N-2-2k]=c_k, h[2N-1]=2^(SRA_BITS-1), and all other h=0.
REQ-016 One output SHALL be produced per accepted odd sample n=2m+1: y[m]=sum_j h[j]*x[2m+1-j], with x[<0]=0.
REQ-017 The implementation SHALL be polyphase: a pre-add of symmetric odd-sample pairs, N multiplies, and the center term as the even-phase delay shifted left by SRA_BITS-1.
REQ-018 Full-precision accumulation SHALL NOT wrap: the width is XIN_WIDTH+COE_WIDTH+1+ceil(log2(N+1)).
REQ-019 Scaling SHALL be an arithmetic shift right by SRA_BITS, then saturation to YOUT_WIDTH signed; ovf=1 exactly when clipping occurred.
REQ-020 yout_valid SHALL pulse exactly L=4+ceil(log2(N+1)) cycles after the cycle accepting x[2m+1] (L=7 for the defaults); the latency is fixed and independent of gaps.
REQ-021 The pipeline SHALL advance every cycle, so back-to-back valids at full rate give yout_valid every second cycle.
REQ-022 yout and ovf SHALL hold their value between strobes.

Reset
REQ-023 When rst_n=0, the delay lines and pipeline SHALL clear to 0, the phase SHALL reset to even (next accepted sample is x[0]), and yout=0, yout_valid=0, ovf=0.
REQ-024 Reset asserted mid-operation SHALL discard all in-flight samples; no yout_valid strobe occurs for pre-reset data.

Configuration
REQ-025 Macro HB_DN2_DEC2_ROUND_EN SHALL control rounding: when defined, 2^(SRA_BITS-1) is added before the shift (round half up); when undefined, the result is truncated (floor).

Structure
REQ-026 Package hb_dn2_pkg SHALL hold the accumulator-width and latency constant functions and the saturate function.
REQ-027 Sub-module hb_dn2_tree SHALL implement the pipelined adder tree of N+1 terms, one register per level.

Verification
REQ-028 Impulse test: x[1]=32767, all else 0, ROUND_EN defined -> y[0..4]=952,-1609,3090,-6260,20622 (ovf=0); the mirrored taps follow in y[5..9].
REQ-029 Center test: x[0]=32767, all else 0 -> y[4]=16384 with ROUND_EN defined, 16383 without; all other y=0.
REQ-030 DC test: x=32767 constant -> steady y=32767 with ovf=1; x=-32768 constant -> y=-32768 with ovf=1.
REQ-031 Gap test: the impulse of REQ-028 with random xin_valid gaps -> identical y sequence, each strobe L cycles after its odd sample.
REQ-032 Reset test: deassert rst_n mid-stream -> outputs are 0 within the same cycle, no stale strobe occurs, and the first output after release equals the clean-start bit-exact model output.

Source files
------------

// File: rtl/hb_dn2_pkg.sv
// rtl/hb_dn2_pkg.sv - width/latency constant functions and output saturation for the half-band decimator
package hb_dn2_pkg;

  function automatic int acc_width(input int xw, input int cw, input int n);
    return xw + cw + 1 + $clog2(n + 1);
  endfunction

  function automatic int latency(input int n);
    return 4 + $clog2(n + 1);
  endfunction

  function automatic logic signed [63:0] sat_hi(input int yw);
    return (64'sd1 <<< (yw - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] sat_lo(input int yw);
    return -sat_hi(yw) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] saturate(input logic signed [63:0] v, input int yw);
    if (v > sat_hi(yw)) return sat_hi(yw);
    if (v < sat_lo(yw)) return sat_lo(yw);
    return v;
  endfunction

  function automatic logic clips(input logic signed [63:0] v, input int yw);
    return (v > sat_hi(yw)) || (v < sat_lo(yw));
  endfunction

endpackage

// File: rtl/hb_dn2_tree.sv
// rtl/hb_dn2_tree.sv - pipelined binary adder tree, one register per level
module hb_dn2_tree
  import hb_dn2_pkg::*;
#(
  parameter int N_TERMS = 6,
  parameter int WIDTH   = 36
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic signed [WIDTH-1:0] terms [N_TERMS],
  output logic signed [WIDTH-1:0] sum,
  output logic                    out_valid
);

  localparam int LEVELS = $clog2(N_TERMS);
  localparam int P      = 1 << LEVELS;

  // Heap layout: node i sums children 2i and 2i+1; indices >= P are the padded leaves.
  logic signed [WIDTH-1:0] leaf [P];
  logic signed [WIDTH-1:0] node [1:P-1];
  logic [LEVELS-1:0]       vld;

  for (genvar i = 0; i < P; i++) begin : g_leaf
    if (i < N_TERMS) begin : g_in
      assign leaf[i] = terms[i];
    end else begin : g_pad
      assign leaf[i] = '0;
    end
  end

  for (genvar i = 1; i < P; i++) begin : g_node
    if (2 * i >= P) begin : g_bottom
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) node[i] <= '0;
        else        node[i] <= leaf[2*i-P] + leaf[2*i+1-P];
      end
    end else begin : g_inner
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) node[i] <= '0;
        else        node[i] <= node[2*i] + node[2*i+1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
    end else begin
      vld[0] <= in_valid;
      for (int i = 1; i < LEVELS; i++) vld[i] <= vld[i-1];
    end
  end

  assign sum       = node[1];
  assign out_valid = vld[LEVELS-1];

endmodule

// File: rtl/hb_dn2_dec2.sv
// rtl/hb_dn2_dec2.sv - polyphase half-band decimate-by-2 filter; HB_DN2_DEC2_ROUND_EN selects round-half-up over floor
module hb_dn2_dec2
  import hb_dn2_pkg::*;
#(
  parameter int XIN_WIDTH      = 16,
  parameter int COE_WIDTH      = 16,
  parameter int NUM_UNIQUE_COE = 5,
  parameter logic signed [COE_WIDTH-1:0] COE_NUMS [NUM_UNIQUE_COE] =
    '{16'sd952, -16'sd1609, 16'sd3090, -16'sd6260, 16'sd20622},
  parameter int YOUT_WIDTH     = 16,
  parameter int SRA_BITS       = 15
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic signed [XIN_WIDTH-1:0]  xin,
  input  logic                         xin_valid,
  output logic signed [YOUT_WIDTH-1:0] yout,
  output logic                         yout_valid,
  output logic                         ovf
);

  localparam int N     = NUM_UNIQUE_COE;
  localparam int ACC_W = acc_width(XIN_WIDTH, COE_WIDTH, NUM_UNIQUE_COE);
  localparam int PRE_W = XIN_WIDTH + 1;
  localparam int PRD_W = PRE_W + COE_WIDTH;

  logic                        phase;
  logic signed [XIN_WIDTH-1:0] od [2*N];
  logic signed [XIN_WIDTH-1:0] ev [N];
  logic                        v0, v1, v2;
  logic signed [PRE_W-1:0]     pre [N];
  logic signed [PRD_W-1:0]     prd [N];
  logic signed [XIN_WIDTH-1:0] ctr1, ctr2;
  logic signed [ACC_W-1:0]     terms [N+1];
  logic signed [ACC_W-1:0]     sum;
  logic                        sum_valid;
  logic signed [ACC_W:0]       rnd, shifted;
  logic signed [63:0]          sat_in;

  // phase=1 means the next accepted sample is odd; an odd sample completes an output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= 1'b0;
      v0    <= 1'b0;
      for (int i = 0; i < 2*N; i++) od[i] <= '0;
      for (int i = 0; i < N; i++)   ev[i] <= '0;
    end else begin
      v0 <= xin_valid & phase;
      if (xin_valid) begin
        phase <= ~phase;
        if (phase) begin
          od[0] <= xin;
          for (int i = 1; i < 2*N; i++) od[i] <= od[i-1];
        end else begin
          ev[0] <= xin;
          for (int i = 1; i < N; i++) ev[i] <= ev[i-1];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1   <= 1'b0;
      v2   <= 1'b0;
      ctr1 <= '0;
      ctr2 <= '0;
      for (int k = 0; k < N; k++) begin
        pre[k] <= '0;
        prd[k] <= '0;
      end
    end else begin
      v1   <= v0;
      v2   <= v1;
      ctr1 <= ev[N-1];
      ctr2 <= ctr1;
      for (int k = 0; k < N; k++) begin
        pre[k] <= PRE_W'(od[k]) + PRE_W'(od[2*N-1-k]);
        prd[k] <= PRD_W'(pre[k]) * PRD_W'(COE_NUMS[k]);
      end
    end
  end

  always_comb begin
    for (int k = 0; k < N; k++) terms[k] = ACC_W'(prd[k]);
    terms[N] = ACC_W'(ctr2) <<< (SRA_BITS - 1);
  end

  hb_dn2_tree #(
    .N_TERMS (N + 1),
    .WIDTH   (ACC_W)
  ) u_tree (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (v2),
    .terms     (terms),
    .sum       (sum),
    .out_valid (sum_valid)
  );

`ifdef HB_DN2_DEC2_ROUND_EN
  localparam logic signed [ACC_W:0] RND_BIAS = (ACC_W + 1)'(1) <<< (SRA_BITS - 1);
  assign rnd = (ACC_W + 1)'(sum) + RND_BIAS;
`else
  assign rnd = (ACC_W + 1)'(sum);
`endif

  assign shifted = rnd >>> SRA_BITS;
  assign sat_in  = 64'(shifted);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      yout       <= '0;
      yout_valid <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      yout_valid <= sum_valid;
      if (sum_valid) begin
        yout <= YOUT_WIDTH'(saturate(sat_in, YOUT_WIDTH));
        ovf  <= clips(sat_in, YOUT_WIDTH);
      end
    end
  end

endmodule

// File: tb/tb_hb_dn2_dec2.sv
// tb/tb_hb_dn2_dec2.sv - bench for hb_dn2_dec2 against a direct-convolution reference model
module tb_hb_dn2_dec2;

  localparam int N   = 5;
  localparam int L   = 7;
  localparam int SRA = 15;
  localparam int NT  = 4 * N - 1;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic signed [15:0] xin = '0;
  logic               xin_valid = 1'b0;
  logic signed [15:0] yout;
  logic               yout_valid;
  logic               ovf;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  hb_dn2_dec2 dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .xin        (xin),
    .xin_valid  (xin_valid),
    .yout       (yout),
    .yout_valid (yout_valid),
    .ovf        (ovf)
  );

  typedef struct {
    longint y;
    logic   o;
    int     due;
  } exp_t;

  longint coe [N] = '{952, -1609, 3090, -6260, 20622};
  longint h [NT];
  longint xs [$];
  exp_t   exq [$];
  longint last_y;
  logic   last_o;
  int     checks = 0;
  int     failures = 0;

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d cycle=%0d", tag, obs, expv, cyc);
    end
  endtask

  // Direct FIR definition: y[m] = sum_j h[j]*x[2m+1-j], scaled, then clipped.
  task automatic accept(input logic signed [15:0] x);
    longint acc;
    longint q;
    int     n;
    exp_t   e;
    xs.push_back(longint'(x));
    n = xs.size() - 1;
    if (n % 2 == 1) begin
      acc = 0;
      for (int j = 0; j < NT; j++)
        if (n - j >= 0) acc += h[j] * xs[n-j];
`ifdef HB_DN2_DEC2_ROUND_EN
      acc += longint'(1) <<< (SRA - 1);
`endif
      q = acc >>> SRA;
      e.o = (q > 32767) || (q < -32768);
      e.y = (q > 32767) ? 32767 : (q < -32768) ? -32768 : q;
      e.due = cyc + L;
      exq.push_back(e);
    end
  endtask

  task automatic check_outputs();
    logic expv;
    while (exq.size() > 0 && exq[0].due < cyc) void'(exq.pop_front());
    expv = (exq.size() > 0) && (exq[0].due == cyc);
    check("yout_valid", 64'(yout_valid), 64'(expv));
    if (expv) begin
      check("yout", 64'(yout), exq[0].y);
      check("ovf", 64'(ovf), 64'(exq[0].o));
      last_y = exq[0].y;
      last_o = exq[0].o;
      void'(exq.pop_front());
    end else begin
      check("yout_hold", 64'(yout), last_y);
      check("ovf_hold", 64'(ovf), 64'(last_o));
    end
  endtask

  task automatic step(input logic v, input logic signed [15:0] x);
    @(negedge clk);
    check_outputs();
    xin_valid = v;
    xin = x;
    if (v) accept(x);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    xin_valid = 1'b0;
    xin = '0;
    #1;
    check("rst_yout", 64'(yout), 64'sd0);
    check("rst_yout_valid", 64'(yout_valid), 64'sd0);
    check("rst_ovf", 64'(ovf), 64'sd0);
    xs.delete();
    exq.delete();
    last_y = 0;
    last_o = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check_outputs();
    end
    rst_n = 1'b1;
  endtask

  function automatic logic signed [15:0] rand_x();
    logic signed [15:0] r;
    r = 16'($urandom);
    if ($urandom_range(0, 1) == 1) r = r >>> 3;
    return r;
  endfunction

  initial begin
    for (int j = 0; j < NT; j++) begin
      h[j] = 0;
      if (j == 2 * N - 1) h[j] = longint'(1) <<< (SRA - 1);
      else if (j % 2 == 0) h[j] = coe[(j < 2 * N - 1) ? j / 2 : (4 * N - 2 - j) / 2];
    end

    do_reset();

    // impulse on the first odd sample, full rate
    step(1'b1, 16'sd0);
    step(1'b1, 16'sh7fff);
    repeat (24) step(1'b1, 16'sd0);

    // impulse on x[0] exercises only the center tap
    do_reset();
    step(1'b1, 16'sh7fff);
    repeat (14) step(1'b1, 16'sd0);

    do_reset();
    repeat (40) step(1'b1, 16'sh7fff);

    do_reset();
    repeat (40) step(1'b1, 16'sh8000);

    // impulse again with random idle gaps carrying junk data
    do_reset();
    for (int i = 0; i < 26; i++) begin
      repeat ($urandom_range(0, 3)) step(1'b0, rand_x());
      step(1'b1, (i == 1) ? 16'sh7fff : 16'sd0);
    end

    // random stream, reset mid-flight, then a clean restart
    do_reset();
    for (int i = 0; i < 120; i++) begin
      if ($urandom_range(0, 3) == 0) step(1'b0, rand_x());
      step(1'b1, rand_x());
    end
    do_reset();
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 3) == 0) step(1'b0, rand_x());
      step(1'b1, rand_x());
    end

    repeat (L + 4) step(1'b0, 16'sd0);
    check("drain_empty", 64'(exq.size()), 64'sd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
